// File: rtl/riser_regs_pkg.sv
// Shared definitions for the riser control/status register bank and its read-back port.
package riser_regs_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_BUS_W = 8;
  localparam int unsigned DEF_NREGS = 4;

  // Reading an index past the bank returns this bit in every position.
  localparam logic OOR_FILL_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } rb_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_readback_port_if.sv
// Host-side request/acknowledge bus of the register read-back port.
interface reg_readback_port_if #(
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned BUS_W  = 8,
  parameter int unsigned BYTE_W = 2
) ();

  logic              idx_wr;
  logic [IDX_W-1:0]  idx_in;
  logic              rd_req;
  logic [BUS_W-1:0]  rd_data;
  logic              rd_ack;
  logic              rd_err;
  logic [IDX_W-1:0]  cur_idx;
  logic [BYTE_W-1:0] cur_byte;

  modport master (
    output idx_wr, idx_in, rd_req,
    input  rd_data, rd_ack, rd_err, cur_idx, cur_byte
  );

  modport slave (
    input  idx_wr, idx_in, rd_req,
    output rd_data, rd_ack, rd_err, cur_idx, cur_byte
  );

endinterface

// File: rtl/byte_select.sv
// Combinational byte picker: returns byte i_byte (byte 0 = least significant) of i_snap.
module byte_select #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BUS_W  = 8,
  parameter int unsigned BYTE_W = 2
) (
  input  logic [WIDTH-1:0]  i_snap,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [BUS_W-1:0]  o_byte
);

  localparam int unsigned NBYTES = WIDTH / BUS_W;

  always_comb begin
    o_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i_byte == BYTE_W'(i)) o_byte = i_snap[i*BUS_W +: BUS_W];
    end
  end

endmodule

// File: rtl/reg_readback_port.sv
// Byte-serial, snapshot-coherent read-back of a register bank over a req/ack handshake.
// Optional READBACK_AUTOINC_EN: index pointer advances (mod NREGS) when the byte pointer wraps.
module reg_readback_port
  import riser_regs_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned BUS_W = DEF_BUS_W,
  parameter int unsigned IDX_W = clog2_min1(NREGS)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NREGS*WIDTH-1:0] i_regs_flat,
  reg_readback_port_if.slave     bus
);

  localparam int unsigned NBYTES = WIDTH / BUS_W;
  localparam int unsigned BYTE_W = clog2_min1(NBYTES);

  rb_state_e         r_state, w_state_nxt;
  logic              r_req_q, r_req_prev;
  logic              r_idx_wr_q;
  logic [IDX_W-1:0]  r_idx_in_q;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt, w_idx_wrap;
  logic [BYTE_W-1:0] r_byte, w_byte_nxt;
  logic              r_load_pend, w_pend_nxt;
  logic [WIDTH-1:0]  r_snap, w_reg_val, w_snap_src;
  logic [BUS_W-1:0]  r_rd_data, w_byte;
  logic              r_rd_err;
  logic              w_req_edge, w_drop, w_last;

  // Inputs are registered first; the request edge is detected on the sampled copy.
  assign w_req_edge = r_req_q & ~r_req_prev;
  assign w_last     = (r_byte == BYTE_W'(NBYTES - 1));

  always_comb begin
    w_reg_val = {WIDTH{OOR_FILL_BIT}};
    for (int i = 0; i < NREGS; i++) begin
      if (r_idx == IDX_W'(i)) w_reg_val = i_regs_flat[i*WIDTH +: WIDTH];
    end
  end

  assign w_snap_src = (r_byte == '0) ? w_reg_val : r_snap;

  byte_select #(
    .WIDTH  (WIDTH),
    .BUS_W  (BUS_W),
    .BYTE_W (BYTE_W)
  ) u_byte_select (
    .i_snap (w_snap_src),
    .i_byte (r_byte),
    .o_byte (w_byte)
  );

`ifdef READBACK_AUTOINC_EN
  logic [IDX_W:0] w_idx_p1;
  assign w_idx_p1   = {1'b0, r_idx} + (IDX_W+1)'(1);
  assign w_idx_wrap = IDX_W'(w_idx_p1 % (IDX_W+1)'(NREGS));
`else
  assign w_idx_wrap = r_idx;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_drop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req_edge) begin
          if (r_idx_wr_q) w_drop      = 1'b1;
          else            w_state_nxt = FETCH;
        end
      end
      FETCH:    w_state_nxt = ACK;
      ACK:      w_state_nxt = r_req_q ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!r_req_q) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // An index load seen during FETCH suppresses the advance in the following ACK.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_byte_nxt = r_byte;
    w_pend_nxt = r_load_pend;
    if (r_state == ACK) begin
      w_pend_nxt = 1'b0;
      if (!r_load_pend) begin
        w_byte_nxt = w_last ? '0 : r_byte + BYTE_W'(1);
        if (w_last) w_idx_nxt = w_idx_wrap;
      end
    end
    if (r_idx_wr_q) begin
      w_idx_nxt  = r_idx_in_q;
      w_byte_nxt = '0;
      if (r_state == FETCH) w_pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_req_q     <= 1'b1;
      r_req_prev  <= 1'b1;
      r_idx_wr_q  <= 1'b0;
      r_idx_in_q  <= '0;
      r_idx       <= '0;
      r_byte      <= '0;
      r_load_pend <= 1'b0;
      r_snap      <= '0;
      r_rd_data   <= '0;
      r_rd_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_q     <= bus.rd_req;
      r_req_prev  <= r_req_q;
      r_idx_wr_q  <= bus.idx_wr;
      r_idx_in_q  <= bus.idx_in;
      r_idx       <= w_idx_nxt;
      r_byte      <= w_byte_nxt;
      r_load_pend <= w_pend_nxt;
      r_rd_err    <= w_drop;
      if (r_state == FETCH) begin
        r_snap    <= w_snap_src;
        r_rd_data <= w_byte;
      end
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_ack   = (r_state == ACK);
  assign bus.rd_err   = r_rd_err;
  assign bus.cur_idx  = r_idx;
  assign bus.cur_byte = r_byte;

endmodule

// File: tb/tb_reg_readback_port.sv
// Self-checking bench for reg_readback_port (NREGS=3 so index 3 is out of range).
module tb_reg_readback_port;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREGS = 3;
  localparam int unsigned BUS_W = 8;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned NB    = WIDTH / BUS_W;
`ifdef READBACK_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WIDTH-1:0]  regs [NREGS];
  logic [NREGS*WIDTH-1:0] regs_flat;

  assign regs_flat = {regs[2], regs[1], regs[0]};

  reg_readback_port_if #(.IDX_W(IDX_W), .BUS_W(BUS_W), .BYTE_W(2)) bus ();

  reg_readback_port #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .BUS_W (BUS_W),
    .IDX_W (IDX_W)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_regs_flat (regs_flat),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index, byte position and the snapshot of the current register.
  int          m_idx = 0;
  int          m_byte = 0;
  logic [31:0] m_snap = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_read(output logic [7:0] d);
    if (m_byte == 0) begin
      if (m_idx < NREGS) m_snap = regs[m_idx];
      else               m_snap = 32'hFFFF_FFFF;
    end
    d = 8'(m_snap >> (8 * m_byte));
    m_byte++;
    if (m_byte == NB) begin
      m_byte = 0;
      if (AI) m_idx = (m_idx + 1) % NREGS;
    end
  endtask

  task automatic do_idx_wr(input int v);
    @(negedge clk);
    bus.idx_wr = 1'b1;
    bus.idx_in = 2'(v);
    @(negedge clk);
    bus.idx_wr = 1'b0;
    repeat (2) @(negedge clk);
    m_idx  = v;
    m_byte = 0;
  endtask

  // One well-formed request: raise, wait for ack (bounded), drop, let the FSM settle.
  task automatic run_read(output logic [7:0] got, output int lat, output int nack);
    got = '0; lat = 0; nack = 0;
    @(negedge clk);
    bus.rd_req = 1'b1;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (bus.rd_ack) begin
        lat = c;
        nack++;
        got = bus.rd_data;
      end
    end
    @(negedge clk);
    bus.rd_req = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.rd_ack) nack++;
    end
  endtask

  task automatic do_read(input string name);
    logic [7:0] exp, got;
    int lat, nack;
    model_read(exp);
    run_read(got, lat, nack);
    check({name, " latency"}, lat, 3);
    check({name, " data"}, got, exp);
    check({name, " ack count"}, nack, 1);
    check({name, " cur_idx"}, bus.cur_idx, m_idx);
    check({name, " cur_byte"}, bus.cur_byte, m_byte);
  endtask

  typedef struct {
    bit          ld;
    int          ld_idx;
    bit          wr;
    int          wr_sel;
    logic [31:0] wr_val;
    logic [7:0]  exp_d;
    int          exp_idx;
    int          exp_byte;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [7:0] got, exp, mdummy;
    int lat, nack, nerr;

    bus.rd_req = 1'b1;
    bus.idx_wr = 1'b0;
    bus.idx_in = '0;
    regs[0] = 32'h4433_2211;
    regs[1] = 32'hAABB_CCDD;
    regs[2] = 32'h0BAD_F00D;

    tbl[0]  = '{1, 0, 0, 0, 0, 8'h11, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 8'h22, 0, 2};
    tbl[2]  = '{0, 0, 0, 0, 0, 8'h33, 0, 3};
    tbl[3]  = '{0, 0, 0, 0, 0, 8'h44, AI ? 1 : 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 8'hDD, 1, 1};
    tbl[5]  = '{0, 0, 1, 1, 32'h0, 8'hCC, 1, 2};
    tbl[6]  = '{0, 0, 0, 0, 0, 8'hBB, 1, 3};
    tbl[7]  = '{0, 0, 0, 0, 0, 8'hAA, AI ? 2 : 1, 0};
    tbl[8]  = '{1, 3, 0, 0, 0, 8'hFF, 3, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 8'hFF, 3, 2};
    tbl[10] = '{0, 0, 0, 0, 0, 8'hFF, 3, 3};
    tbl[11] = '{0, 0, 0, 0, 0, 8'hFF, AI ? 1 : 3, 0};

    // Reset values, with rd_req held high through reset.
    repeat (3) @(negedge clk);
    check("reset rd_ack", bus.rd_ack, 0);
    check("reset rd_err", bus.rd_err, 0);
    check("reset rd_data", bus.rd_data, 0);
    check("reset cur_idx", bus.cur_idx, 0);
    check("reset cur_byte", bus.cur_byte, 0);
    rst_n = 1'b1;
    nack = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rd_ack) nack++;
    end
    check("held through reset no ack", nack, 0);
    @(negedge clk);
    bus.rd_req = 1'b0;
    repeat (3) @(negedge clk);

    // Directed table: sequential bytes, snapshot coherence, out-of-range fill.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].ld) do_idx_wr(tbl[i].ld_idx);
      if (tbl[i].wr) begin
        @(negedge clk);
        regs[tbl[i].wr_sel] = tbl[i].wr_val;
      end
      model_read(mdummy);
      run_read(got, lat, nack);
      check($sformatf("tbl%0d latency", i), lat, 3);
      check($sformatf("tbl%0d data", i), got, tbl[i].exp_d);
      check($sformatf("tbl%0d ack count", i), nack, 1);
      check($sformatf("tbl%0d cur_idx", i), bus.cur_idx, tbl[i].exp_idx);
      check($sformatf("tbl%0d cur_byte", i), bus.cur_byte, tbl[i].exp_byte);
    end

    // idx_wr coincident with the request edge: dropped with one rd_err.
    regs[1] = 32'hAABB_CCDD;
    do_idx_wr(0);
    do_read("pre-drop");
    @(negedge clk);
    bus.rd_req = 1'b1;
    bus.idx_wr = 1'b1;
    bus.idx_in = 2'd2;
    nack = 0; nerr = 0;
    @(posedge clk); #1;
    if (bus.rd_ack) nack++;
    if (bus.rd_err) nerr++;
    @(negedge clk);
    bus.idx_wr = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
      if (bus.rd_ack) nack++;
      if (bus.rd_err) nerr++;
    end
    check("drop rd_err pulses", nerr, 1);
    check("drop rd_ack", nack, 0);
    check("drop cur_idx", bus.cur_idx, 2);
    check("drop cur_byte", bus.cur_byte, 0);
    @(negedge clk);
    bus.rd_req = 1'b0;
    repeat (3) @(negedge clk);
    m_idx = 2; m_byte = 0;

    // Request held for 10 cycles gives exactly one ack.
    model_read(exp);
    @(negedge clk);
    bus.rd_req = 1'b1;
    nack = 0; got = '0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.rd_ack) begin
        nack++;
        got = bus.rd_data;
      end
    end
    @(negedge clk);
    bus.rd_req = 1'b0;
    repeat (4) @(negedge clk);
    check("held req ack count", nack, 1);
    check("held req data", got, exp);

    // idx_wr during FETCH: byte from old snapshot, pointer ends at new index, byte 0.
    do_idx_wr(0);
    do_read("pre-fetch-load");
    model_read(exp);
    @(negedge clk);
    bus.rd_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.idx_wr = 1'b1;
    bus.idx_in = 2'd1;
    @(posedge clk);
    @(negedge clk);
    bus.idx_wr = 1'b0;
    nack = 0; got = '0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.rd_ack) begin
        nack++;
        got = bus.rd_data;
      end
    end
    @(negedge clk);
    bus.rd_req = 1'b0;
    repeat (4) @(negedge clk);
    check("fetch-load ack count", nack, 1);
    check("fetch-load data", got, exp);
    check("fetch-load cur_idx", bus.cur_idx, 1);
    check("fetch-load cur_byte", bus.cur_byte, 0);
    m_idx = 1; m_byte = 0;

    // Reset asserted while in FETCH.
    do_idx_wr(2);
    do_read("pre-reset");
    @(negedge clk);
    bus.rd_req = 1'b1;
    nack = 0;
    @(posedge clk); #1;
    if (bus.rd_ack) nack++;
    @(posedge clk); #1;
    if (bus.rd_ack) nack++;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rd_req = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.rd_ack) nack++;
    end
    check("reset-in-fetch ack", nack, 0);
    check("reset-in-fetch cur_idx", bus.cur_idx, 0);
    check("reset-in-fetch cur_byte", bus.cur_byte, 0);
    check("reset-in-fetch rd_data", bus.rd_data, 0);
    m_idx = 0; m_byte = 0;

    // Eight reads from index 0 (streams into reg1 only with auto-increment).
    regs[0] = 32'h4433_2211;
    regs[1] = 32'hAABB_CCDD;
    do_idx_wr(0);
    for (int i = 0; i < 8; i++) do_read($sformatf("stream%0d", i));
    check("stream final cur_idx", bus.cur_idx, AI ? 2 : 0);

    // Randomized traffic: index loads and register changes between reads.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) do_idx_wr(int'($urandom_range(0, 3)));
      else if (r < 5) begin
        @(negedge clk);
        regs[$urandom_range(0, NREGS - 1)] = $urandom;
      end
      do_read($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end, got hang, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_readback_port.md
# reg_readback_port

Byte-serial read-back port for the riser's bank of WIDTH-bit control/status registers. It is the read-side counterpart of the dual-load register: it presents register contents to the host-side bus interface one BUS_W-bit byte at a time, using a coherent snapshot and a request/acknowledge handshake. The block sits between the register bank (parallel, flattened input) and the host-bus data-out mux.

## Interface
- WIDTH, 32: register width in bits; must be a multiple of BUS_W.
- NREGS, 4: number of registers in the bank; must be at least 1.
- BUS_W, 8: host data-bus width.
- IDX_W, 2: index pointer width; IDX_W = max(1, clog2(NREGS)).
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low.
- regs_flat  in  NREGS*WIDTH  register bank; register i occupies bits [i*WIDTH +: WIDTH].
- idx_wr  in  1  single-cycle strobe that loads idx_in into the index pointer.
- idx_in  in  IDX_W  register index to load.
- rd_req  in  1  read request level, held by the requester until rd_ack.
- rd_data  out  BUS_W  byte returned; valid only while rd_ack=1.
- rd_ack  out  1  one-cycle acknowledge.
- rd_err  out  1  one-cycle pulse when a request is dropped.
- cur_idx  out  IDX_W  current index pointer.
- cur_byte  out  clog2(WIDTH/BUS_W) (minimum 1)  next byte position.

## Operation
- Index pointer and byte pointer:
  - idx_wr loads idx_in into the index pointer and clears the byte pointer to 0.
  - The byte pointer always addresses byte 0 = least-significant byte first.
- Snapshot:
  - When a request is accepted with byte pointer = 0, the whole addressed register is copied into a WIDTH-bit snapshot.
  - All bytes of one register are returned from that single snapshot, so a multi-byte read is coherent even if regs_flat changes.
- Request acceptance:
  - A request is a rising edge of rd_req: sampled high now, low on the previous cycle.
  - A level held high after rd_ack does not generate another read. The requester must drop rd_req for at least 1 cycle between requests.
- State machine:
  - IDLE → FETCH on an accepted request.
  - FETCH → ACK. In FETCH the snapshot is taken (if byte pointer = 0) and the byte is selected into rd_data.
  - ACK → WAIT_LOW if rd_req is still high, otherwise → IDLE. rd_ack=1 for the single ACK cycle. The byte pointer advances in ACK.
  - WAIT_LOW → IDLE when rd_req=0.
- Byte pointer wrap:
  - After the last byte (WIDTH/BUS_W − 1), the byte pointer wraps to 0.
  - The next request then takes a fresh snapshot.
- Out-of-range index (index ≥ NREGS): the read returns all ones (0xFF for BUS_W=8). The acknowledge and pointer behaviour are otherwise normal.
- Simultaneous events:
  - idx_wr coincident with an accepted request: idx_wr takes priority, the request is dropped, and rd_err pulses.
  - idx_wr while in FETCH or ACK: the in-flight byte completes from the old snapshot. The pointer load then takes effect and the byte pointer ends at 0, not the advanced value.

## Timing
- Reset values:
  - State = IDLE.
  - rd_data = 0, rd_ack = 0, rd_err = 0.
  - cur_idx = 0, cur_byte = 0.
  - Snapshot = 0.
  - Previous-rd_req flop = 1, so a request held high through reset is not accepted until it is seen low.
- Latency: rd_req rises, sampled at edge N → rd_ack=1 and rd_data valid in the cycle following edge N+2. The latency is fixed at 2 cycles and does not depend on whether a snapshot is taken.
- rd_data is registered. It holds its value after ACK until the next ACK.
- Reset asserted mid-read: the state returns to IDLE on that edge, no rd_ack is issued, and all pointers are cleared.
- Throughput: at most one byte every 4 cycles (IDLE, FETCH, ACK, low cycle).

## Configuration
- Macro READBACK_AUTOINC_EN.
- Defined: when the byte pointer wraps, the index pointer also increments, modulo NREGS, so consecutive reads stream through the whole bank.
- Undefined: the index pointer changes only on idx_wr; repeated reads re-read the same register with fresh snapshots.

## Structure
- Shared package (riser_regs_pkg):
  - State encoding constants IDLE/FETCH/ACK/WAIT_LOW.
  - The out-of-range fill value.
  - Default WIDTH/BUS_W/NREGS.
- Sub-module byte_select: purely combinational. It takes the snapshot and the byte pointer and produces one byte. It is instantiated once.

## Test plan
- Bank reg0=0x44332211, index 0, four separate requests → rd_data 0x11, 0x22, 0x33, 0x44, each rd_ack exactly 2 cycles after the rd_req edge.
- Snapshot coherence: after byte 0 of reg1=0xAABBCCDD is read, change reg1 to 0x00000000 → the remaining bytes still read 0xCC, 0xBB, 0xAA.
- idx_wr to 2 in the same cycle as a rd_req edge → rd_err pulses once, no rd_ack, cur_idx=2, cur_byte=0.
- With NREGS=3, load index 3 → four reads return 0xFF with normal rd_ack.
- rd_req held high for 10 cycles → exactly one rd_ack. Reset asserted in FETCH → no rd_ack, cur_idx=0, cur_byte=0.
- With READBACK_AUTOINC_EN, eight reads from index 0 → bytes of reg0 then reg1, and cur_idx ends at 2. Without the macro → reg0 is read twice and cur_idx stays 0.
